cpu_stack: RTL

CPU_STACK -- requirements
Module: cpu_stack

---
 rtl/cpu_stack_pkg.sv | 14 +
 rtl/cpu_stack_ram.sv | 38 +++
 rtl/cpu_stack.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_stack_pkg.sv
// Shared constants for the CPU call/data stack.
package cpu_stack_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 128;

  // Stack pointer needs one extra bit so that sp == DEPTH (full) is representable.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DEFAULT_SP_W = sp_width(DEFAULT_DEPTH);

endpackage

// File: rtl/cpu_stack_ram.sv
// Stack storage: one synchronous write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module stack_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic                       rd_clr,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: zeroed by reset or a synchronous clear, otherwise holds until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cpu_stack.sv
// Hardware push/pop stack for the CPU: register data pushed, popped word fed to writeback.
module cpu_stack
  import cpu_stack_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             d,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         hold,
  input  logic                         clear,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic                         empty,
  output logic                         full,
  output logic [sp_width(DEPTH)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         conflict
);

  localparam int unsigned SP_W = sp_width(DEPTH);
  localparam int unsigned AW   = SP_W - 1;

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_nxt;
  logic            push_ok;
  logic            pop_ok;
  logic            pop_any;
  logic            ovf_set;
  logic            unf_set;
  logic            cfl_set;
  logic            rd_clr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   rd_addr;

  // Status decodes of the stack pointer.
  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));
  assign depth = sp;

  // Request qualification and next stack pointer.
  always_comb begin
    logic accept;
    logic do_push;
    logic do_pop;
    accept  = ~hold & ~clear;
    do_push = accept & push & ~pop;
    do_pop  = accept & pop & ~push;

    push_ok = do_push & ~full;
    pop_ok  = do_pop & ~empty;
    pop_any = do_pop;
    ovf_set = do_push & full;
    unf_set = do_pop & empty;
    cfl_set = accept & push & pop;
    rd_clr  = clear | unf_set;

    sp_nxt = sp;
    if (clear) begin
      sp_nxt = '0;
    end else if (push_ok) begin
      sp_nxt = sp + SP_W'(1);
    end else if (pop_ok) begin
      sp_nxt = sp - SP_W'(1);
    end
  end

  // Write at sp, read at sp-1 so the popped word lands in q on the request edge.
  // A write is suppressed whenever reset is high, including the edge it overlaps.
  assign wr_addr = AW'(sp);
  assign rd_addr = AW'(sp) - AW'(1);
  assign wr_en   = push_ok & ~reset;

  // Stack pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else begin
      sp <= sp_nxt;
    end
  end

  // Pop-result strobe and sticky error flags; clear wipes the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else if (clear) begin
      q_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      q_valid   <= pop_any;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
      conflict  <= conflict | cfl_set;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (d),
    .rd_en   (pop_ok),
    .rd_clr  (rd_clr),
    .rd_addr (rd_addr),
    .rd_data (q)
  );

endmodule
